// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU types: datapath words, ALU ops, pipeline entries
//                and the per-stage payload structs carried by pipe_stage_buf.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  localparam int WORD_W      = 32;
  localparam int PIPE_DATA_W = 32;
  localparam int REG_IDX_W   = 5;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_NOP  = 4'd11
  } aluop_t;

  typedef struct packed {
    logic                   halt;
    logic [PIPE_DATA_W-1:0] data;
  } pipe_entry_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } if_id_t;

  typedef struct packed {
    word_t    pc;
    word_t    rs1_val;
    word_t    rs2_val;
    word_t    imm;
    reg_idx_t rd;
    aluop_t   aluop;
    logic     alu_src_imm;
    logic     mem_read;
    logic     mem_write;
    logic     reg_write;
  } id_ex_t;

  typedef struct packed {
    word_t    alu_result;
    word_t    store_val;
    reg_idx_t rd;
    logic     mem_read;
    logic     mem_write;
    logic     reg_write;
  } ex_mem_t;

  typedef struct packed {
    word_t    wb_val;
    reg_idx_t rd;
    logic     reg_write;
  } mem_wb_t;

  // A single-entry buffer still needs a 1-bit pointer type to stay legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ============================================================================
//  Module      : pipe_stage_buf
//  Description : Elastic valid/ready pipeline stage with flush and sticky halt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_buf
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_halt,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic              halt;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_halted;
  logic             w_push;
  logic             w_pop;
  entry_t           w_head;

  // Ready is built from registered state and flush only, keeping out_ready
  // off the in_ready path.
  assign in_ready  = (r_count != C_FULL) && !r_halted && !flush;
  assign out_valid = (r_count != '0) && !flush;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_data  = out_valid ? w_head.data : '0;
  assign out_halt  = out_valid && w_head.halt;
  assign count     = r_count;
  assign halted    = r_halted;

  generate
    if (DEPTH == 1) begin : g_single
      assign w_head = r_mem[0];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[0] <= '0;
        end else if (w_push) begin
          r_mem[0] <= '{halt: in_halt, data: in_data};
        end
      end
    end else begin : g_multi
      logic [PTR_W-1:0] r_wr_ptr;
      logic [PTR_W-1:0] r_rd_ptr;

      assign w_head = r_mem[r_rd_ptr];

      // DEPTH is a power of two, so natural overflow gives the wrap.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else if (flush) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else begin
          if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
          r_mem[r_wr_ptr] <= '{halt: in_halt, data: in_data};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Flush forces out_valid low, so a squashed halt word never sets this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (w_pop && w_head.halt) begin
      r_halted <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// ============================================================================
//  Module      : tb_pipe_stage_buf
//  Description : Directed bench for pipe_stage_buf at DEPTH = 2, 1 and 8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DEPTH = 2 instance
  logic        flush = 0, in_valid = 0, in_halt = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic        in_ready, out_valid, out_halt, halted;
  logic [31:0] out_data;
  logic [1:0]  count;

  // DEPTH = 1 instance
  logic        d1_in_valid = 0, d1_out_ready = 0;
  logic [31:0] d1_in_data = 0;
  logic        d1_in_ready, d1_out_valid, d1_out_halt, d1_halted;
  logic [31:0] d1_out_data;
  logic [0:0]  d1_count;

  // DEPTH = 8 instance
  logic        d8_in_valid = 0, d8_out_ready = 0;
  logic [31:0] d8_in_data = 0;
  logic        d8_in_ready, d8_out_valid, d8_out_halt, d8_halted;
  logic [31:0] d8_out_data;
  logic [3:0]  d8_count;

  pipe_stage_buf #(.DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
    .count(count), .halted(halted)
  );

  pipe_stage_buf #(.DATA_W(32), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data), .in_halt(1'b0),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .out_halt(d1_out_halt), .count(d1_count), .halted(d1_halted)
  );

  pipe_stage_buf #(.DATA_W(32), .DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready), .in_data(d8_in_data), .in_halt(1'b0),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready), .out_data(d8_out_data),
    .out_halt(d8_out_halt), .count(d8_count), .halted(d8_halted)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        flush, in_valid;
    logic [31:0] in_data;
    logic        in_halt, out_ready;
    logic        e_out_valid;
    logic [31:0] e_out_data;
    logic        e_out_halt, e_in_ready;
    logic [1:0]  e_count;
    logic        e_halted;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int f, iv, d, h, ordy, ov, od, oh, ir, cnt, hl);
    vec_t v;
    v.flush = f[0]; v.in_valid = iv[0]; v.in_data = d; v.in_halt = h[0];
    v.out_ready = ordy[0]; v.e_out_valid = ov[0]; v.e_out_data = od;
    v.e_out_halt = oh[0]; v.e_in_ready = ir[0]; v.e_count = cnt[1:0]; v.e_halted = hl[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic run_vec(input vec_t v, input int idx);
    flush = v.flush; in_valid = v.in_valid; in_data = v.in_data;
    in_halt = v.in_halt; out_ready = v.out_ready;
    #1;
    check($sformatf("v%0d.out_valid", idx), 32'(out_valid), 32'(v.e_out_valid));
    check($sformatf("v%0d.out_data", idx),  out_data,       v.e_out_data);
    check($sformatf("v%0d.out_halt", idx),  32'(out_halt),  32'(v.e_out_halt));
    check($sformatf("v%0d.in_ready", idx),  32'(in_ready),  32'(v.e_in_ready));
    check($sformatf("v%0d.count", idx),     32'(count),     32'(v.e_count));
    check($sformatf("v%0d.halted", idx),    32'(halted),    32'(v.e_halted));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pushed, popped;
    logic p, q;

    // Stream 0x1..0x8 with downstream always ready.
    vecs.push_back(mk(0,1,1,0,1, 0,0,0,1,0,0));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(0,1,k+1,0,1, 1,k,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,1, 1,8,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,1, 0,0,0,1,0,0));
    // Backpressure: 0xC waits upstream until a slot frees.
    vecs.push_back(mk(0,1,'hA,0,0, 0,0,0,1,0,0));
    vecs.push_back(mk(0,1,'hB,0,0, 1,'hA,0,1,1,0));
    vecs.push_back(mk(0,1,'hC,0,0, 1,'hA,0,0,2,0));
    vecs.push_back(mk(0,1,'hC,0,1, 1,'hA,0,0,2,0));
    vecs.push_back(mk(0,1,'hC,0,1, 1,'hB,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,1, 1,'hC,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,1, 0,0,0,1,0,0));
    // Flush colliding with push and pop on a full stage.
    vecs.push_back(mk(0,1,'h11,0,0, 0,0,0,1,0,0));
    vecs.push_back(mk(0,1,'h12,0,0, 1,'h11,0,1,1,0));
    vecs.push_back(mk(1,1,'h13,0,1, 0,0,0,0,2,0));
    vecs.push_back(mk(0,0,0,0,1, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,0,0,1,0,0));
    // Halt word 0x6 freezes intake once it leaves; later flush keeps halted.
    vecs.push_back(mk(0,1,5,0,0, 0,0,0,1,0,0));
    vecs.push_back(mk(0,1,6,1,0, 1,5,0,1,1,0));
    vecs.push_back(mk(0,1,7,0,0, 1,5,0,0,2,0));
    vecs.push_back(mk(0,1,7,0,1, 1,5,0,0,2,0));
    vecs.push_back(mk(0,1,7,0,1, 1,6,1,1,1,0));
    vecs.push_back(mk(0,0,0,0,1, 1,7,0,0,1,1));
    vecs.push_back(mk(0,1,9,0,1, 0,0,0,0,0,1));
    vecs.push_back(mk(1,1,9,0,1, 0,0,0,0,0,1));
    vecs.push_back(mk(0,1,9,0,1, 0,0,0,0,0,1));

    // Reset state, sampled while rst_n is still low.
    #3;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.out_data",  out_data,       0);
    check("rst.in_ready",  32'(in_ready),  1);
    check("rst.count",     32'(count),     0);
    check("rst.halted",    32'(halted),    0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Clear the sticky halt, then fill to two entries.
    in_valid = 0; flush = 0; out_ready = 0;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(mk(0,1,'h31,0,0, 0,0,0,1,0,0), 100);
    run_vec(mk(0,1,'h32,0,0, 1,'h31,0,1,1,0), 101);
    in_valid = 0;
    #1;
    check("pre_areset.count", 32'(count), 2);
    rst_n = 1'b0;
    #1;
    check("areset.out_valid", 32'(out_valid), 0);
    check("areset.out_data",  out_data,       0);
    check("areset.count",     32'(count),     0);
    check("areset.in_ready",  32'(in_ready),  1);
    check("areset.halted",    32'(halted),    0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(mk(0,1,'h41,0,1, 0,0,0,1,0,0), 110);
    run_vec(mk(0,1,'h42,0,1, 1,'h41,0,1,1,0), 111);
    run_vec(mk(0,0,0,0,1, 1,'h42,0,1,1,0), 112);
    run_vec(mk(0,0,0,0,1, 0,0,0,1,0,0), 113);

    // DEPTH = 1: continuous offer, downstream ready -> one word per two cycles.
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      d1_in_valid = 1; d1_in_data = 32'(pushed + 'h100); d1_out_ready = 1;
      #1;
      p = d1_in_valid && d1_in_ready;
      q = d1_out_valid && d1_out_ready;
      if (q) check("d1.data", d1_out_data, 32'(popped + 'h100));
      @(posedge clk); #1;
      if (p) pushed++;
      if (q) popped++;
    end
    d1_in_valid = 0;
    check("d1.delivered", 32'(popped), 10);

    // DEPTH = 8: fill under backpressure, then drain 20 words across wraps.
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 200 && popped < 20; cyc++) begin
      d8_in_valid = (pushed < 20); d8_in_data = 32'(pushed + 'h200);
      d8_out_ready = (cyc >= 10);
      #1;
      if (cyc == 9) begin
        check("d8.full_count", 32'(d8_count), 8);
        check("d8.full_in_ready", 32'(d8_in_ready), 0);
      end
      p = d8_in_valid && d8_in_ready;
      q = d8_out_valid && d8_out_ready;
      if (q) check("d8.data", d8_out_data, 32'(popped + 'h200));
      @(posedge clk); #1;
      if (p) pushed++;
      if (q) popped++;
    end
    d8_in_valid = 0;
    check("d8.delivered", 32'(popped), 20);
    #1;
    check("d8.empty_count", 32'(d8_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
